// File: rtl/gpreg_bus_sequencer_pkg.sv
// Shared types and the source-index decode for the register-bank bus sequencer.
package gpreg_seq_pkg;
  localparam int MAX_REGS  = 8;
  localparam int IDX_W     = 3;
  localparam int NUM_BUSES = 3;
  localparam int BUS_MAIN  = 0;
  localparam int BUS_LHS   = 1;
  localparam int BUS_RHS   = 2;

  typedef enum logic [1:0] {IDLE, SETTLE, STROBE, HOLD} seq_state_t;

  typedef struct packed {
    logic [NUM_BUSES-1:0]            en;
    logic [NUM_BUSES-1:0][IDX_W-1:0] src;
  } cmd_t;

  // A disabled bus decodes to all-ones, so it never drives and never trips range checks.
  function automatic logic [MAX_REGS-1:0] src_to_bar(input logic en, input logic [IDX_W-1:0] idx);
    logic [MAX_REGS-1:0] onehot;
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
    return ~onehot;
  endfunction
endpackage

// File: rtl/gpreg_bus_sequencer_if.sv
// Command handshake plus register-bank strobes between control unit and sequencer.
interface gpreg_bus_sequencer_if #(parameter int NUM_REGS = 4);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                CMD_VALID;
  logic                CMD_READY;
  logic                CMD_MAIN_EN;
  logic                CMD_LHS_EN;
  logic                CMD_RHS_EN;
  logic [IW-1:0]       CMD_MAIN_SRC;
  logic [IW-1:0]       CMD_LHS_SRC;
  logic [IW-1:0]       CMD_RHS_SRC;
  logic [NUM_REGS-1:0] CMD_DST_MASK;
  logic [NUM_REGS-1:0] ASSERT_MAIN_bar;
  logic [NUM_REGS-1:0] ASSERT_LHS_bar;
  logic [NUM_REGS-1:0] ASSERT_RHS_bar;
  logic [NUM_REGS-1:0] LOAD;
  logic                DONE;
  logic                ERR;

  modport master (
    output CMD_VALID, CMD_MAIN_EN, CMD_LHS_EN, CMD_RHS_EN,
           CMD_MAIN_SRC, CMD_LHS_SRC, CMD_RHS_SRC, CMD_DST_MASK,
    input  CMD_READY, ASSERT_MAIN_bar, ASSERT_LHS_bar, ASSERT_RHS_bar, LOAD, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_MAIN_EN, CMD_LHS_EN, CMD_RHS_EN,
           CMD_MAIN_SRC, CMD_LHS_SRC, CMD_RHS_SRC, CMD_DST_MASK,
    output CMD_READY, ASSERT_MAIN_bar, ASSERT_LHS_bar, ASSERT_RHS_bar, LOAD, DONE, ERR
  );
endinterface

// File: rtl/gpreg_bus_sequencer_settle_timer.sv
// Loadable down-counter timing how long source drivers settle before LOAD.
// Holds at zero once expired; expire flag is decoded from the count flop.
module gpreg_seq_settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/gpreg_bus_sequencer.sv
// Sequences bus enables and a single LOAD strobe per transfer; SETTLE_CYCLES+3 cycles per command.
// Accepts one command only in IDLE (CMD_READY from the state flop); all strobes are registered.
module gpreg_bus_sequencer
  import gpreg_seq_pkg::*;
#(
  parameter int NUM_REGS      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  CLK,
  input logic                  RST_bar,
  gpreg_bus_sequencer_if.slave bus
);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  seq_state_t           state;
  cmd_t                 cmd_in;
  logic [MAX_REGS-1:0]  dec [NUM_BUSES];
  logic [NUM_BUSES-1:0] bad;
  logic                 accept;
  logic                 reject;
  logic                 tmr_expired;
  logic [NUM_REGS-1:0]  dst_q;
  logic [NUM_REGS-1:0]  main_bar_q;
  logic [NUM_REGS-1:0]  lhs_bar_q;
  logic [NUM_REGS-1:0]  rhs_bar_q;
  logic [NUM_REGS-1:0]  load_q;
  logic                 done_q;
  logic                 err_q;

  always_comb begin
    cmd_in               = '0;
    cmd_in.en[BUS_MAIN]  = bus.CMD_MAIN_EN;
    cmd_in.en[BUS_LHS]   = bus.CMD_LHS_EN;
    cmd_in.en[BUS_RHS]   = bus.CMD_RHS_EN;
    cmd_in.src[BUS_MAIN] = IDX_W'(bus.CMD_MAIN_SRC);
    cmd_in.src[BUS_LHS]  = IDX_W'(bus.CMD_LHS_SRC);
    cmd_in.src[BUS_RHS]  = IDX_W'(bus.CMD_RHS_SRC);
    for (int b = 0; b < NUM_BUSES; b++) begin
      dec[b] = src_to_bar(cmd_in.en[b], cmd_in.src[b]);
    end
  end

  // An out-of-range source shows up as its one-hot zero landing above the bank.
  if (NUM_REGS < MAX_REGS) begin : g_range
    always_comb begin
      bad = '0;
      for (int b = 0; b < NUM_BUSES; b++) begin
        bad[b] = ~&dec[b][MAX_REGS-1:NUM_REGS];
      end
    end
  end else begin : g_full
    assign bad = '0;
  end

  assign accept = bus.CMD_VALID && (state == IDLE);
  assign reject = accept && (|bad);

  gpreg_seq_settle_timer #(.WIDTH(TW)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_bar),
    .load     (accept && !reject),
    .load_val (TW'(SETTLE_CYCLES - 1)),
    .dec      (state == SETTLE),
    .expired  (tmr_expired)
  );

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state      <= IDLE;
      dst_q      <= '0;
      main_bar_q <= '1;
      lhs_bar_q  <= '1;
      rhs_bar_q  <= '1;
      load_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (reject) begin
            err_q <= 1'b1;
          end else if (accept) begin
            dst_q      <= bus.CMD_DST_MASK;
            main_bar_q <= dec[BUS_MAIN][NUM_REGS-1:0];
            lhs_bar_q  <= dec[BUS_LHS][NUM_REGS-1:0];
            rhs_bar_q  <= dec[BUS_RHS][NUM_REGS-1:0];
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_expired) begin
            load_q <= dst_q;
            state  <= STROBE;
          end
        end
        STROBE: begin
          load_q <= '0;
          state  <= HOLD;
        end
        HOLD: begin
          main_bar_q <= '1;
          lhs_bar_q  <= '1;
          rhs_bar_q  <= '1;
          done_q     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CMD_READY       = (state == IDLE);
  assign bus.ASSERT_MAIN_bar = main_bar_q;
  assign bus.ASSERT_LHS_bar  = lhs_bar_q;
  assign bus.ASSERT_RHS_bar  = rhs_bar_q;
  assign bus.LOAD            = load_q;
  assign bus.DONE            = done_q;
  assign bus.ERR             = err_q;
endmodule

// File: doc/gpreg_bus_sequencer.md
# gpreg_bus_sequencer

Control-path sequencer that drives the LOAD and ASSERT_*_bar strobes of a bank of 8-bit general-purpose registers. It accepts one transfer command at a time, enables at most one source register per bus (MAIN, LHS, RHS), waits for the buses to settle, then issues a single clean rising edge on the LOAD line of every destination register. It sits between the microcode/control unit and the register bank, and guarantees no bus contention and no glitches on register clocks.

## Interface

Parameters:
- NUM_REGS, 4: number of registers in the bank (2..8); index width IW = clog2(NUM_REGS).
- SETTLE_CYCLES, 1: cycles the source drivers are enabled before LOAD rises (≥1).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_bar  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command; a command is taken on a CLK edge with CMD_VALID & CMD_READY.
- CMD_MAIN_EN / CMD_LHS_EN / CMD_RHS_EN  in  1 each  drive the corresponding bus.
- CMD_MAIN_SRC / CMD_LHS_SRC / CMD_RHS_SRC  in  IW each  source register index per bus.
- CMD_DST_MASK  in  NUM_REGS  registers to load from MAIN bus.
- ASSERT_MAIN_bar / ASSERT_LHS_bar / ASSERT_RHS_bar  out  NUM_REGS each  active-low per-register bus enables.
- LOAD  out  NUM_REGS  per-register load clocks (register latches on rising edge).
- DONE  out  1  one-cycle pulse when a transfer completes.
- ERR  out  1  one-cycle pulse when a command is rejected.

## Operation

- States: IDLE, SETTLE, STROBE, HOLD.
- IDLE: CMD_READY=1; all ASSERT_*_bar high, LOAD all 0. On accept, latch command; validate; go SETTLE (or stay IDLE with ERR).
- Validation: any enabled SRC index ≥ NUM_REGS -> reject: ERR pulses next cycle, no strobes, remain IDLE. Disabled fields ignored.
- SETTLE: for each enabled bus, drive exactly bit SRC low in its ASSERT_*_bar; counter runs SETTLE_CYCLES cycles, then STROBE.
- STROBE: LOAD = latched DST_MASK for exactly one cycle; ASSERT_* unchanged.
- HOLD: LOAD all 0, ASSERT_* still held (hold time for registers); next cycle IDLE with all enables released and DONE=1.
- DST_MASK=0: full sequence runs (assert-only transfer), LOAD stays 0.
- SRC in DST_MASK (self-reload) permitted; no special handling.
- Same register on several buses permitted (separate drivers per bus).
- CMD_VALID while not in IDLE: ignored (CMD_READY=0); requester holds command.
- All outputs come from flops: no combinational path from CMD_* to ASSERT_*_bar, LOAD, DONE, ERR. CMD_READY may be decoded from state flop only.

## Timing

- Reset (asynchronous, immediate, also mid-transfer): state IDLE, ASSERT_*_bar all 1, LOAD all 0, DONE 0, ERR 0, CMD_READY 1. Latched command discarded; any LOAD high falls immediately.
- Accept at edge T0 -> ASSERT low from T0+1 through T0+SETTLE_CYCLES+2; LOAD high during cycle T0+SETTLE_CYCLES+1 only; DONE high and enables released in cycle T0+SETTLE_CYCLES+3.
- Total occupancy: SETTLE_CYCLES+3 cycles; next command acceptable on the edge ending the DONE cycle (CMD_READY=1 during DONE).
- Reject: ERR high in cycle T0+1, CMD_READY stays 1; back-to-back reject/accept allowed.
- LOAD never glitches: exactly one 0->1 and one 1->0 transition per destination per transfer.

## Structure

- Package gpreg_seq_pkg: state enum (IDLE, SETTLE, STROBE, HOLD), command struct type, bus index constants (BUS_MAIN, BUS_LHS, BUS_RHS).
- Sub-module gpreg_seq_settle_timer: loadable down-counter, width clog2(SETTLE_CYCLES+1), expire flag.
- One-hot decode of SRC to active-low enable vector done in a function in the package.

## Test plan

- Reset: RST_bar low mid-STROBE with LOAD=4'b0010 -> all outputs reset values immediately, CMD_READY=1 after release.
- NUM_REGS=4, SETTLE_CYCLES=1: MAIN_SRC=2, DST_MASK=4'b1001 -> ASSERT_MAIN_bar=4'b1011 for 3 cycles, LOAD=4'b1001 in 2nd cycle, DONE in 4th.
- ALU operand fetch: LHS_SRC=0, RHS_SRC=3, MAIN disabled, DST_MASK=0 -> ASSERT_LHS_bar=4'b1110, ASSERT_RHS_bar=4'b0111, LOAD stays 0, DONE after 4 cycles.
- NUM_REGS=6, MAIN_SRC=7 -> ERR one cycle, no output activity; following valid command accepted next edge.
- SETTLE_CYCLES=3, CMD_VALID held during transfer with changing fields -> ignored until DONE cycle; second command accepted exactly on DONE edge, LOAD count per register equals command count.
